// File: rtl/dmem_pkg.sv
// Shared types, funct3 codes and byte-enable helper for the RV32I data memory controller.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // Byte lanes touched by a store of the given size at the given (already aligned) offset.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response handshake bundle between the MEM stage and the data memory controller.
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_load_align.sv
// Combinational lane select and sign/zero extension of a loaded word.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        rdata_c  = 32'h0;
        case (funct3_i)
            F3_B:    rdata_c = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    rdata_c = {{16{half_sel[15]}}, half_sel};
            F3_W:    rdata_c = word_i;
            F3_BU:   rdata_c = {24'h0, byte_sel};
            F3_HU:   rdata_c = {16'h0, half_sel};
            default: rdata_c = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// RV32I data memory with valid/ready handshake and configurable response latency.
// Macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses error instead of force-aligning.
module data_memory_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned LATENCY     = 1
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0] mem_q [DEPTH_WORDS];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dmem_req_t        req_q, req_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    dmem_req_t        acc_c;
    logic [1:0]       off_c;
    logic             mis_c;
    logic             legal_c;
    logic             err_c;
    logic [IDX_W-1:0] idx_c;
    logic [31:0]      word_c;
    logic [31:0]      ld_c;
    logic [31:0]      wdata_c;
    logic [3:0]       be_c;
    logic             enter_resp_c;
    logic             wr_en_c;
    logic             unused_addr_c;

    // With zero latency the access is performed on the accept edge, so decode the live bus in IDLE.
    always_comb begin
        if (state_q == IDLE) begin
            acc_c.we     = bus.req_we;
            acc_c.funct3 = bus.req_funct3;
            acc_c.addr   = bus.req_addr;
            acc_c.wdata  = bus.req_wdata;
        end else begin
            acc_c = req_q;
        end
    end

    assign unused_addr_c = ^acc_c.addr[31:IDX_W+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        off_c = acc_c.addr[1:0];
        mis_c = ((acc_c.funct3 == F3_H || acc_c.funct3 == F3_HU) && acc_c.addr[0]) ||
                ((acc_c.funct3 == F3_W) && (acc_c.addr[1:0] != 2'b00));
    end
`else
    always_comb begin
        mis_c = 1'b0;
        case (acc_c.funct3)
            F3_H, F3_HU: off_c = {acc_c.addr[1], 1'b0};
            F3_W:        off_c = 2'b00;
            default:     off_c = acc_c.addr[1:0];
        endcase
    end
`endif

    always_comb begin
        if (acc_c.we) begin
            legal_c = (acc_c.funct3 == F3_B) || (acc_c.funct3 == F3_H) || (acc_c.funct3 == F3_W);
        end else begin
            legal_c = (acc_c.funct3 == F3_B)  || (acc_c.funct3 == F3_H) || (acc_c.funct3 == F3_W) ||
                      (acc_c.funct3 == F3_BU) || (acc_c.funct3 == F3_HU);
        end
        err_c = !legal_c || mis_c;
    end

    assign idx_c  = acc_c.addr[IDX_W+1:2];
    assign word_c = mem_q[idx_c];
    assign be_c   = byte_en(acc_c.funct3, off_c);

    // Replicate store data across lanes so byte enables alone pick the target bytes.
    always_comb begin
        case (acc_c.funct3)
            F3_B:    wdata_c = {4{acc_c.wdata[7:0]}};
            F3_H:    wdata_c = {2{acc_c.wdata[15:0]}};
            default: wdata_c = acc_c.wdata;
        endcase
    end

    dmem_load_align u_load_align (
        .word_i   (word_c),
        .off_i    (off_c),
        .funct3_i (acc_c.funct3),
        .rdata_c  (ld_c)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        enter_resp_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    req_d       = acc_c;
                    req_ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase

        if (enter_resp_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_c;
            rsp_rdata_d = (acc_c.we || err_c) ? 32'h0 : ld_c;
        end
    end

    assign wr_en_c = enter_resp_c && acc_c.we && !err_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is never cleared; a reset on the commit edge drops the pending store.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem_q[idx_c][8*b +: 8] <= wdata_c[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl (DEPTH_WORDS=32, LATENCY=2); honours DMEM_MISALIGN_TRAP_EN.
module tb_data_memory_ctrl;
    import dmem_pkg::*;

    localparam int unsigned LAT = 2;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam logic [31:0] W10_FINAL = 32'hAB00_00F1;
`else
    localparam logic [31:0] W10_FINAL = 32'hDEAD_BEEF;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_if bus ();

    data_memory_ctrl #(
        .DEPTH_WORDS (32),
        .LATENCY     (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then compare the response against the scoreboard entry pushed here.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input int unsigned hold);
        exp_t        e;
        int unsigned cyc;
        logic        acc;
        logic [31:0] rd0;
        logic        er0;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 20) begin
            acc = bus.req_ready;
            tick();
            cyc++;
        end
        bus.req_valid = 1'b0;
        check_val({tag, "/accept"}, 32'(acc), 32'd1);
        while (!bus.rsp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check_val({tag, "/latency"}, 32'(cyc), 32'(LAT + 1));
        rd0 = bus.rsp_rdata;
        er0 = bus.rsp_err;
        for (int i = 0; i < int'(hold); i++) begin
            tick();
            check_val({tag, "/hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check_val({tag, "/hold_rdata"}, bus.rsp_rdata, rd0);
            check_val({tag, "/hold_err"},   32'(bus.rsp_err), 32'(er0));
            check_val({tag, "/hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        e = sb_q.pop_front();
        check_val({tag, "/rdata"}, bus.rsp_rdata, e.rdata);
        check_val({tag, "/err"},   32'(bus.rsp_err), 32'(e.err));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_val({tag, "/rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
        check_val({tag, "/ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_val("rst/req_ready", 32'(bus.req_ready), 32'd1);
        check_val("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst/rsp_rdata", bus.rsp_rdata, 32'h0);
        check_val("rst/rsp_err",   32'(bus.rsp_err), 32'd0);

        do_req("sw10",  1'b1, F3_W,  32'h10, 32'h8000_00F1, 32'h0,         1'b0, 0);
        do_req("lw10",  1'b0, F3_W,  32'h10, 32'h0,         32'h8000_00F1, 1'b0, 0);
        do_req("lb10",  1'b0, F3_B,  32'h10, 32'h0,         32'hFFFF_FFF1, 1'b0, 0);
        do_req("lbu10", 1'b0, F3_BU, 32'h10, 32'h0,         32'h0000_00F1, 1'b0, 0);
        do_req("lh12",  1'b0, F3_H,  32'h12, 32'h0,         32'hFFFF_8000, 1'b0, 0);
        do_req("lhu12", 1'b0, F3_HU, 32'h12, 32'h0,         32'h0000_8000, 1'b0, 0);

        do_req("sb13",  1'b1, F3_B,  32'h13, 32'h1234_56AB, 32'h0,         1'b0, 0);
        do_req("lw10b", 1'b0, F3_W,  32'h10, 32'h0,         32'hAB00_00F1, 1'b0, 0);
        do_req("lw90",  1'b0, F3_W,  32'h90, 32'h0,         32'hAB00_00F1, 1'b0, 0);

        do_req("sw14",  1'b1, F3_W,  32'h14, 32'h1122_3344, 32'h0,         1'b0, 0);
        do_req("sh16",  1'b1, F3_H,  32'h16, 32'hCAFE_BEEF, 32'h0,         1'b0, 0);
        do_req("lw14",  1'b0, F3_W,  32'h14, 32'h0,         32'hBEEF_3344, 1'b0, 0);
        do_req("lb15",  1'b0, F3_B,  32'h15, 32'h0,         32'h0000_0033, 1'b0, 0);
        do_req("lb17",  1'b0, F3_B,  32'h17, 32'h0,         32'hFFFF_FFBE, 1'b0, 0);
        do_req("lh14",  1'b0, F3_H,  32'h14, 32'h0,         32'h0000_3344, 1'b0, 0);
        do_req("lhu16", 1'b0, F3_HU, 32'h16, 32'h0,         32'h0000_BEEF, 1'b0, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
        do_req("lw11",  1'b0, F3_W,  32'h11, 32'h0,         32'h0,         1'b1, 0);
        do_req("sw12",  1'b1, F3_W,  32'h12, 32'hDEAD_BEEF, 32'h0,         1'b1, 0);
        do_req("lh13",  1'b0, F3_H,  32'h13, 32'h0,         32'h0,         1'b1, 0);
`else
        do_req("lw11",  1'b0, F3_W,  32'h11, 32'h0,         32'hAB00_00F1, 1'b0, 0);
        do_req("sw12",  1'b1, F3_W,  32'h12, 32'hDEAD_BEEF, 32'h0,         1'b0, 0);
        do_req("lh13",  1'b0, F3_H,  32'h13, 32'h0,         32'hFFFF_DEAD, 1'b0, 0);
`endif
        do_req("lw10h", 1'b0, F3_W,  32'h10, 32'h0,         W10_FINAL,     1'b0, 5);

        do_req("ld011", 1'b0, 3'b011, 32'h10, 32'h0,        32'h0,         1'b1, 0);
        do_req("st100", 1'b1, 3'b100, 32'h10, 32'h0000_0000, 32'h0,        1'b1, 0);
        do_req("lw10c", 1'b0, F3_W,  32'h10, 32'h0,         W10_FINAL,     1'b0, 0);

        // Store aborted by reset while waiting must leave the old word intact.
        do_req("sw20",  1'b1, F3_W,  32'h20, 32'h5555_5555, 32'h0,         1'b0, 0);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_W;
        bus.req_addr   = 32'h20;
        bus.req_wdata  = 32'hFFFF_FFFF;
        check_val("abort/ready_pre", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check_val("abort/in_wait", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort/rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("abort/req_ready", 32'(bus.req_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | bus.rsp_valid;
        end
        check_val("abort/no_rsp", 32'(seen), 32'd0);
        do_req("lw20",  1'b0, F3_W,  32'h20, 32'h0,         32'h5555_5555, 1'b0, 0);

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
